memory_responder: RTL and testbench
===================================

# memory_responder

Data-memory responder at the far end of the pipeline's memory request interface. It accepts store requests from the write stage (`address_enable`/`address`/`data`, completed by a `data_valid` pulse) and load requests from the read stage. It drives one word-wide external memory port with a ready/wait-state handshake and returns exactly one completion pulse per accepted request. Stores take priority over loads. A timeout counter guarantees that a stuck memory cannot hang the pipeline.

## Interface

Parameters:
- `MEM_ADDRESS_WIDTH`, 30 — word-address width on the memory port; byte address bits [MEM_ADDRESS_WIDTH+1:2] are used.
- `TIMEOUT_CYCLES`, 255 — maximum wait cycles with `mem_ready` low before abort; 0 disables the timeout.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `address_enable`  in  1  store request from the write stage; held high until `data_valid`.
- `address`  in  32  store byte address.
- `data`  in  32  store data.
- `data_valid`  out  1  one-cycle store-completion pulse.
- `read_enable`  in  1  load request from the read stage; held high until `read_valid`.
- `read_address`  in  32  load byte address.
- `read_data`  out  32  load result; valid while `read_valid` is high.
- `read_valid`  out  1  one-cycle load-completion pulse.
- `bus_error`  out  1  high with `data_valid`/`read_valid` when the access timed out.
- `mem_request`  out  1  memory access in progress.
- `mem_write`  out  1  1 = write, 0 = read; valid while `mem_request` is high.
- `mem_address`  out  MEM_ADDRESS_WIDTH  word address.
- `mem_write_data`  out  32  write data.
- `mem_read_data`  in  32  read data; sampled when `mem_ready` is high.
- `mem_ready`  in  1  memory completes the current access this cycle.

## Operation

- States: IDLE, WRITE, READ, RESPOND.
- IDLE:
  - If `address_enable` is high, latch `address[MEM_ADDRESS_WIDTH+1:2]` and `data`, then go to WRITE.
  - Otherwise, if `read_enable` is high, latch the read address and go to READ.
  - If both are high, WRITE wins. The load stays pending, and its requester keeps `read_enable` high.
- WRITE/READ:
  - `mem_request` is high, and `mem_write`, `mem_address`, `mem_write_data` are held stable from latched registers.
  - When `mem_ready` is sampled high: capture `mem_read_data` (READ only), clear `bus_error`, go to RESPOND.
  - Timeout: a wait counter resets on entry and increments each cycle `mem_ready` is low. When it equals TIMEOUT_CYCLES (nonzero), go to RESPOND with `bus_error`=1 and `read_data`=0.
- RESPOND:
  - Exactly one of `data_valid`/`read_valid` is high for this single cycle, matching the completed access.
  - `mem_request` is low.
  - Request inputs are ignored this cycle because they still carry the completing request.
  - Next state is IDLE.
- Address bits [1:0] and bits above MEM_ADDRESS_WIDTH+1 are ignored; there is no alignment check.
- Reset in any state: next edge is IDLE.
  - All outputs go to 0: `mem_request`, `mem_write`, `mem_address`, `mem_write_data`, `data_valid`, `read_valid`, `read_data`, `bus_error`.
  - The wait counter is cleared.
  - An aborted access produces no completion pulse.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- Request sampled high at edge k (IDLE): `mem_request` is high from cycle k+1.
- `mem_ready` sampled high at edge j: `mem_request` is low and the completion pulse is high in cycle j+1.
- Minimum latency with a zero-wait memory: request first high in cycle 0, completion pulse in cycle 2.
- Back-to-back requests: a new request is accepted at the earliest one cycle after the pulse (IDLE), i.e. one access per 3 cycles with zero-wait memory.
- Timeout: with `mem_ready` stuck low, the pulse with `bus_error` occurs TIMEOUT_CYCLES+1 cycles after `mem_request` first rises.
- `mem_ready` sampled while `mem_request` is low is ignored.

## Test plan

- Store with zero-wait memory: `address_enable`=1, `address`=0x0000_0104, `data`=0xDEAD_BEEF in cycle 0, `mem_ready`=1 → cycle 1: `mem_request`=1, `mem_write`=1, `mem_address`=0x41, `mem_write_data`=0xDEAD_BEEF; cycle 2: `data_valid`=1 for one cycle, `bus_error`=0; exactly one memory write.
- Load with 3 wait states: `read_address`=0x20, `mem_read_data`=0x1234_5678 with `mem_ready` high in cycle 4 → `mem_address`=0x8 stable in cycles 1–4; `read_valid`=1 and `read_data`=0x1234_5678 in cycle 5.
- Simultaneous store (0x10) and load (0x14) held high → store is issued first, `data_valid` pulses, one IDLE cycle follows, then the load is issued and `read_valid` pulses. No request is issued twice.
- Timeout with TIMEOUT_CYCLES=4 and `mem_ready`=0 → `mem_request` is high in cycles 1–5; cycle 6: `data_valid`=1, `bus_error`=1; cycle 7: IDLE.
- Reset asserted in cycle 2 of a 5-wait-state read → cycle 3: all outputs are 0 and no `read_valid` is ever pulsed. A new read accepted after reset completes normally.

Source files
------------

// File: rtl/memory_responder.sv
// Far-end data-memory responder: arbitrates store/load requests onto one
// word-wide memory port with wait states, timeout abort and one completion pulse.
module memory_responder #(
  parameter int MEM_ADDRESS_WIDTH = 30,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         address_enable,
  input  logic [31:0]                  address,
  input  logic [31:0]                  data,
  output logic                         data_valid,
  input  logic                         read_enable,
  input  logic [31:0]                  read_address,
  output logic [31:0]                  read_data,
  output logic                         read_valid,
  output logic                         bus_error,
  output logic                         mem_request,
  output logic                         mem_write,
  output logic [MEM_ADDRESS_WIDTH-1:0] mem_address,
  output logic [31:0]                  mem_write_data,
  input  logic [31:0]                  mem_read_data,
  input  logic                         mem_ready
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESPOND} state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         req_q, req_d;
  logic                         wr_q, wr_d;
  logic [MEM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]                  wdata_q, wdata_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic                         dv_q, dv_d;
  logic                         rv_q, rv_d;
  logic                         berr_q, berr_d;
  logic                         busy, timeout_hit, done;

  assign busy        = (state_q == WRITE) || (state_q == READ);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES));
  assign done        = busy && (mem_ready || timeout_hit);

  // Byte-offset and out-of-range address bits are intentionally dropped.
  logic unused_addr_bits;
  if (MEM_ADDRESS_WIDTH < 30) begin : g_hi_unused
    assign unused_addr_bits = ^{address[1:0], read_address[1:0],
                                address[31:MEM_ADDRESS_WIDTH+2],
                                read_address[31:MEM_ADDRESS_WIDTH+2]};
  end else begin : g_lo_unused
    assign unused_addr_bits = ^{address[1:0], read_address[1:0]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dv_q    <= 1'b0;
      rv_q    <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dv_q    <= dv_d;
      rv_q    <= rv_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (address_enable)   state_d = WRITE;
        else if (read_enable) state_d = READ;
      end
      WRITE, READ: if (done) state_d = RESPOND;
      RESPOND:     state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, so every port comes straight from a flop.
  always_comb begin
    cnt_d   = cnt_q;
    req_d   = req_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    dv_d    = 1'b0;
    rv_d    = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (address_enable) begin
          req_d   = 1'b1;
          wr_d    = 1'b1;
          addr_d  = address[MEM_ADDRESS_WIDTH+1:2];
          wdata_d = data;
        end else if (read_enable) begin
          req_d  = 1'b1;
          wr_d   = 1'b0;
          addr_d = read_address[MEM_ADDRESS_WIDTH+1:2];
        end
      end
      WRITE, READ: begin
        if (done) begin
          req_d  = 1'b0;
          dv_d   = (state_q == WRITE);
          rv_d   = (state_q == READ);
          berr_d = !mem_ready;
          if (state_q == READ) rdata_d = mem_ready ? mem_read_data : 32'h0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign mem_request    = req_q;
  assign mem_write      = wr_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign read_data      = rdata_q;
  assign data_valid     = dv_q;
  assign read_valid     = rv_q;
  assign bus_error      = berr_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with a transaction-level reference model
// checked every cycle plus hand-computed literal expectations.
module tb_memory_responder;
  localparam int T = 4;

  logic        clock, reset;
  logic        address_enable, read_enable;
  logic [31:0] address, data, read_address, mem_read_data;
  logic        mem_ready;
  logic        data_valid, read_valid, bus_error, mem_request, mem_write;
  logic [31:0] read_data, mem_write_data;
  logic [29:0] mem_address;

  memory_responder #(.MEM_ADDRESS_WIDTH(30), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset),
    .address_enable(address_enable), .address(address), .data(data),
    .data_valid(data_valid),
    .read_enable(read_enable), .read_address(read_address),
    .read_data(read_data), .read_valid(read_valid), .bus_error(bus_error),
    .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_ready(mem_ready)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  int checks = 0, errors = 0;
  int writes = 0, issues = 0;
  bit armed = 0, req_prev = 0, dv_s = 0, rv_s = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding access; completes when the memory is ready
  // or after the request has been up for T+1 cycles; one pulse, then idle.
  logic        exp_req = 0, exp_wr = 0, exp_dv = 0, exp_rv = 0, exp_be = 0;
  logic [29:0] exp_addr = 0;
  logic [31:0] exp_wd = 0, exp_rd = 0;
  int          n = 0;

  always @(posedge clock) begin
    if (reset) begin
      exp_req <= 0; exp_wr <= 0; exp_dv <= 0; exp_rv <= 0; exp_be <= 0;
      exp_addr <= 0; exp_wd <= 0; exp_rd <= 0; n <= 0;
    end else if (exp_dv || exp_rv) begin
      exp_dv <= 0; exp_rv <= 0; exp_be <= 0;
    end else if (exp_req) begin
      n <= n + 1;
      if (mem_ready || (T != 0 && n + 1 == T + 1)) begin
        exp_req <= 0;
        exp_be  <= !mem_ready;
        exp_dv  <= exp_wr;
        exp_rv  <= !exp_wr;
        if (!exp_wr) exp_rd <= mem_ready ? mem_read_data : 32'h0;
      end
    end else if (address_enable) begin
      exp_req <= 1; exp_wr <= 1; exp_addr <= address >> 2; exp_wd <= data; n <= 0;
    end else if (read_enable) begin
      exp_req <= 1; exp_wr <= 0; exp_addr <= read_address >> 2; n <= 0;
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("req", {31'b0, mem_request}, {31'b0, exp_req});
      chk("dv", {31'b0, data_valid}, {31'b0, exp_dv});
      chk("rv", {31'b0, read_valid}, {31'b0, exp_rv});
      if (exp_dv || exp_rv) chk("berr", {31'b0, bus_error}, {31'b0, exp_be});
      if (exp_req) begin
        chk("mw", {31'b0, mem_write}, {31'b0, exp_wr});
        chk("addr", {2'b0, mem_address}, {2'b0, exp_addr});
        if (exp_wr) chk("wdata", mem_write_data, exp_wd);
      end
      if (exp_rv) chk("rdata", read_data, exp_rd);
      if (mem_request && !req_prev) issues++;
      if (mem_request && mem_write && mem_ready) writes++;
      req_prev = mem_request;
    end
  end

  task automatic neg();
    @(negedge clock);
    dv_s = data_valid;
    rv_s = read_valid;
  endtask

  // Requesters drop their enable once they have seen their completion pulse.
  task automatic adv();
    @(posedge clock);
    #1;
    if (dv_s) address_enable = 0;
    if (rv_s) read_enable = 0;
    dv_s = 0;
    rv_s = 0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req"}, {31'b0, mem_request}, 0);
    chk({nm, "_mw"}, {31'b0, mem_write}, 0);
    chk({nm, "_addr"}, {2'b0, mem_address}, 0);
    chk({nm, "_wdata"}, mem_write_data, 0);
    chk({nm, "_dv"}, {31'b0, data_valid}, 0);
    chk({nm, "_rv"}, {31'b0, read_valid}, 0);
    chk({nm, "_rdata"}, read_data, 0);
    chk({nm, "_berr"}, {31'b0, bus_error}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int w0, i0;

  initial begin
    reset = 1; address_enable = 0; read_enable = 0; address = 0; data = 0;
    read_address = 0; mem_read_data = 0; mem_ready = 0;
    neg(); adv();
    armed = 1;
    neg(); adv();
    reset = 0;
    neg(); chk_all_zero("rst"); adv();

    // Store, zero-wait memory
    w0 = writes;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin
        address_enable = 1; address = 32'h0000_0104; data = 32'hDEAD_BEEF; mem_ready = 1;
      end
      neg();
      case (c)
        1: begin
          chk("t1_req", {31'b0, mem_request}, 1);
          chk("t1_mw", {31'b0, mem_write}, 1);
          chk("t1_addr", {2'b0, mem_address}, 32'h41);
          chk("t1_wdata", mem_write_data, 32'hDEAD_BEEF);
        end
        2: begin
          chk("t1_dv", {31'b0, data_valid}, 1);
          chk("t1_berr", {31'b0, bus_error}, 0);
          chk("t1_req_lo", {31'b0, mem_request}, 0);
        end
        3: chk("t1_dv_lo", {31'b0, data_valid}, 0);
        default: ;
      endcase
      adv();
    end
    chk("t1_writes", writes - w0, 1);

    // Load with three wait states
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin read_enable = 1; read_address = 32'h20; end
      mem_ready = (c == 4);
      mem_read_data = (c == 4) ? 32'h1234_5678 : 32'hFFFF_0000;
      neg();
      if (c >= 1 && c <= 4) begin
        chk("t2_req", {31'b0, mem_request}, 1);
        chk("t2_addr", {2'b0, mem_address}, 32'h8);
        chk("t2_rv_lo", {31'b0, read_valid}, 0);
      end
      if (c == 5) begin
        chk("t2_rv", {31'b0, read_valid}, 1);
        chk("t2_rdata", read_data, 32'h1234_5678);
        chk("t2_berr", {31'b0, bus_error}, 0);
      end
      if (c == 6) chk("t2_rv_end", {31'b0, read_valid}, 0);
      adv();
    end

    // Simultaneous store and load: store first, one idle cycle, then load
    i0 = issues;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        address_enable = 1; address = 32'h10; data = 32'hCAFE_F00D;
        read_enable = 1; read_address = 32'h14;
        mem_ready = 1; mem_read_data = 32'h0BAD_CAFE;
      end
      neg();
      case (c)
        1: begin
          chk("t3_mw1", {31'b0, mem_write}, 1);
          chk("t3_addr1", {2'b0, mem_address}, 32'h4);
        end
        2: chk("t3_dv", {31'b0, data_valid}, 1);
        3: chk("t3_idle", {31'b0, mem_request}, 0);
        4: begin
          chk("t3_mw0", {31'b0, mem_write}, 0);
          chk("t3_addr2", {2'b0, mem_address}, 32'h5);
        end
        5: begin
          chk("t3_rv", {31'b0, read_valid}, 1);
          chk("t3_rdata", read_data, 32'h0BAD_CAFE);
        end
        default: ;
      endcase
      adv();
    end
    chk("t3_issues", issues - i0, 2);

    // Timeout with memory stuck not-ready
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        address_enable = 1; address = 32'h40; data = 32'h55; mem_ready = 0;
      end
      neg();
      if (c >= 1 && c <= 5) chk("t4_req", {31'b0, mem_request}, 1);
      if (c == 6) begin
        chk("t4_dv", {31'b0, data_valid}, 1);
        chk("t4_berr", {31'b0, bus_error}, 1);
        chk("t4_req_lo", {31'b0, mem_request}, 0);
      end
      if (c == 7) chk("t4_idle", {31'b0, mem_request | data_valid}, 0);
      adv();
    end

    // Reset in the middle of a slow read, then a clean read
    for (int c = 0; c < 13; c++) begin
      case (c)
        0: begin read_enable = 1; read_address = 32'h80; mem_ready = 0; end
        2: begin reset = 1; read_enable = 0; end
        3: reset = 0;
        9: begin
          read_enable = 1; read_address = 32'h84; mem_ready = 1;
          mem_read_data = 32'hA5A5_A5A5;
        end
        default: ;
      endcase
      neg();
      if (c == 1) chk("t5_addr", {2'b0, mem_address}, 32'h20);
      if (c == 2) chk("t5_req", {31'b0, mem_request}, 1);
      if (c == 3) chk_all_zero("t5_rst");
      if (c >= 4 && c <= 8) chk("t5_no_rv", {31'b0, read_valid}, 0);
      if (c == 10) chk("t5_addr2", {2'b0, mem_address}, 32'h21);
      if (c == 11) begin
        chk("t5_rv", {31'b0, read_valid}, 1);
        chk("t5_rdata", read_data, 32'hA5A5_A5A5);
      end
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
